operand_fetch: RTL and testbench

Pipelined read-issue stage between an instruction/request source and the dual-read register memory. It accepts a request carrying up to two register addresses and drives the memory's two combinational read ports in the acceptance cycle. It captures both operands into an output register with a 2-entry skid buffer and presents them downstream under a valid/ready handshake. An optional write-snoop bypass forwards same-cycle register writes into the captured operands.

---
 rtl/operand_fetch.sv | 118 +++++++++++
 tb/tb_operand_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: issues dual register reads and holds captured operands in an M + skid pair.
// Optional define OPERAND_FETCH_BYPASS_EN forwards same-cycle register writes into captured operands.
module operand_fetch #(
  parameter int BitWidth = 8,
  parameter int Depth    = 16,
  parameter int TagWidth = 4,
  localparam int AW      = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_useA,
  input  logic                req_useB,
  input  logic [AW-1:0]       req_addrA,
  input  logic [AW-1:0]       req_addrB,
  input  logic [TagWidth-1:0] req_tag,
  output logic                rEnA,
  output logic                rEnB,
  output logic [AW-1:0]       rAddrA,
  output logic [AW-1:0]       rAddrB,
  input  logic [BitWidth-1:0] dOUTA,
  input  logic [BitWidth-1:0] dOUTB,
  input  logic                wEn,
  input  logic [AW-1:0]       wAddr,
  input  logic [BitWidth-1:0] dIN,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BitWidth-1:0] rsp_opA,
  output logic [BitWidth-1:0] rsp_opB,
  output logic [TagWidth-1:0] rsp_tag
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e                state_q;
  logic [BitWidth-1:0]   mOpA_q, mOpB_q, sOpA_q, sOpB_q;
  logic [TagWidth-1:0]   mTag_q, sTag_q;
  logic [BitWidth-1:0]   capA_d, capB_d;
  logic                  accept, pop;

  assign rEnA   = req_valid & req_useA;
  assign rEnB   = req_valid & req_useB;
  assign rAddrA = req_addrA;
  assign rAddrB = req_addrB;

  assign req_ready = clk_en & (state_q != TWO);
  assign rsp_valid = (state_q != EMPTY);
  assign accept    = req_valid & req_ready & clk_en;
  assign pop       = rsp_valid & rsp_ready & clk_en;

  assign rsp_opA = mOpA_q;
  assign rsp_opB = mOpB_q;
  assign rsp_tag = mTag_q;

`ifdef OPERAND_FETCH_BYPASS_EN
  // A write landing on the same edge wins over the stale memory read
  logic hitA, hitB;
  assign hitA   = clk_en & wEn & (wAddr == req_addrA);
  assign hitB   = clk_en & wEn & (wAddr == req_addrB);
  assign capA_d = req_useA ? (hitA ? dIN : dOUTA) : '0;
  assign capB_d = req_useB ? (hitB ? dIN : dOUTB) : '0;
`else
  logic unusedSnoop;
  assign unusedSnoop = ^{wEn, wAddr, dIN};
  assign capA_d = req_useA ? dOUTA : '0;
  assign capB_d = req_useB ? dOUTB : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      mOpA_q  <= '0;
      mOpB_q  <= '0;
      mTag_q  <= '0;
      sOpA_q  <= '0;
      sOpB_q  <= '0;
      sTag_q  <= '0;
    end else if (clk_en) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            mOpA_q  <= capA_d;
            mOpB_q  <= capB_d;
            mTag_q  <= req_tag;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            mOpA_q <= capA_d;
            mOpB_q <= capB_d;
            mTag_q <= req_tag;
          end else if (accept) begin
            sOpA_q  <= capA_d;
            sOpB_q  <= capB_d;
            sTag_q  <= req_tag;
            state_q <= TWO;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          // req_ready is low here, so only a pop can happen
          if (pop) begin
            mOpA_q  <= sOpA_q;
            mOpB_q  <= sOpB_q;
            mTag_q  <= sTag_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 16x8 register memory.
// Bypass expectations follow OPERAND_FETCH_BYPASS_EN.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, req_valid, req_ready, req_useA, req_useB;
  logic [3:0] req_addrA, req_addrB, req_tag, rAddrA, rAddrB, wAddr, rsp_tag;
  logic       rEnA, rEnB, wEn, rsp_valid, rsp_ready;
  logic [7:0] dOUTA, dOUTB, dIN, rsp_opA, rsp_opB;
  logic [7:0] mem [16];
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       useA, useB;
    logic [3:0] addrA, addrB, tag;
    logic [7:0] expA, expB;
  } vec_t;
  vec_t vecs[6];

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_useA(req_useA), .req_useB(req_useB),
    .req_addrA(req_addrA), .req_addrB(req_addrB), .req_tag(req_tag),
    .rEnA(rEnA), .rEnB(rEnB), .rAddrA(rAddrA), .rAddrB(rAddrB),
    .dOUTA(dOUTA), .dOUTB(dOUTB),
    .wEn(wEn), .wAddr(wAddr), .dIN(dIN),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_opA(rsp_opA), .rsp_opB(rsp_opB), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  assign dOUTA = rEnA ? mem[rAddrA] : 8'h00;
  assign dOUTB = rEnB ? mem[rAddrB] : 8'h00;

  always @(posedge clk) begin
    if (wEn) mem[wAddr] <= dIN;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRsp(input string name, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] t);
    checkOutput({name, " valid"}, {31'd0, rsp_valid}, {31'd0, v});
    checkOutput({name, " opA"}, {24'd0, rsp_opA}, {24'd0, a});
    checkOutput({name, " opB"}, {24'd0, rsp_opB}, {24'd0, b});
    checkOutput({name, " tag"}, {28'd0, rsp_tag}, {28'd0, t});
  endtask

  task automatic applyStimulus(input logic v, input logic ua, input logic ub,
                               input logic [3:0] aa, input logic [3:0] ab, input logic [3:0] t);
    req_valid = v;
    req_useA  = ua;
    req_useB  = ub;
    req_addrA = aa;
    req_addrB = ab;
    req_tag   = t;
  endtask

  function automatic logic [7:0] initVal(input int i);
    case (i)
      3:       return 8'h5A;
      4:       return 8'h11;
      7:       return 8'hC3;
      15:      return 8'hFF;
      default: return 8'hA0 + 8'(i);
    endcase
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd3,  4'd7,  4'd9,  8'h5A, 8'hC3};
    vecs[1] = '{1'b1, 1'b0, 4'd3,  4'd7,  4'd2,  8'h5A, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  4'd15, 4'd15, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 1'b1, 4'd15, 4'd15, 4'd0,  8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 1'b1, 4'd0,  4'd1,  4'd5,  8'hA0, 8'hA1};
    vecs[5] = '{1'b0, 1'b0, 4'd3,  4'd7,  4'd6,  8'h00, 8'h00};

    rst_n = 1'b0;
    clk_en = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    wEn = 1'b0; wAddr = 4'd0; dIN = 8'h00;

    // Preload the register memory through its write port while reset is held
    for (int i = 0; i < 16; i++) begin
      wEn = 1'b1; wAddr = 4'(i); dIN = initVal(i);
      tick();
    end
    wEn = 1'b0;
    checkRsp("reset", 1'b0, 8'h00, 8'h00, 4'd0);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].useA, vecs[i].useB, vecs[i].addrA, vecs[i].addrB, vecs[i].tag);
      #1;
      checkOutput($sformatf("vec%0d rEnA", i), {31'd0, rEnA}, {31'd0, vecs[i].useA});
      checkOutput($sformatf("vec%0d rEnB", i), {31'd0, rEnB}, {31'd0, vecs[i].useB});
      checkOutput($sformatf("vec%0d rAddrA", i), {28'd0, rAddrA}, {28'd0, vecs[i].addrA});
      checkOutput($sformatf("vec%0d rAddrB", i), {28'd0, rAddrB}, {28'd0, vecs[i].addrB});
      checkOutput($sformatf("vec%0d req_ready", i), {31'd0, req_ready}, 32'd1);
      tick();
      checkRsp($sformatf("vec%0d", i), 1'b1, vecs[i].expA, vecs[i].expB, vecs[i].tag);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("drain valid", {31'd0, rsp_valid}, 32'd0);

    // Bypass: register 4 holds 0x11 and is written in the accept cycle
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 4'd7);
    wEn = 1'b1; wAddr = 4'd4; dIN = 8'h22;
    tick();
`ifdef OPERAND_FETCH_BYPASS_EN
    checkRsp("bypass1", 1'b1, 8'h22, 8'h22, 4'd7);
`else
    checkRsp("bypass1", 1'b1, 8'h11, 8'h11, 4'd7);
`endif
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 4'd8);
    dIN = 8'h33;
    tick();
`ifdef OPERAND_FETCH_BYPASS_EN
    checkRsp("bypass2", 1'b1, 8'h00, 8'h33, 4'd8);
`else
    checkRsp("bypass2", 1'b1, 8'h00, 8'h22, 4'd8);
`endif
    wEn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();

    // Skid: three requests against a stalled consumer, reg3 rewritten meanwhile
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 4'd7, 4'd1);
    tick();
    checkRsp("skid t1", 1'b1, 8'h5A, 8'hC3, 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 4'd15, 4'd2);
    tick();
    checkOutput("skid full req_ready", {31'd0, req_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 4'd3);
    wEn = 1'b1; wAddr = 4'd3; dIN = 8'h77;
    tick();
    wEn = 1'b0;
    checkOutput("skid t3 pending req_ready", {31'd0, req_ready}, 32'd0);
    checkRsp("skid hold t1", 1'b1, 8'h5A, 8'hC3, 4'd1);
    rsp_ready = 1'b1;
    tick();
    checkRsp("skid t2", 1'b1, 8'h33, 8'hFF, 4'd2);
    checkOutput("skid one req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    checkRsp("skid t3", 1'b1, 8'hA0, 8'hA1, 4'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("skid drained", {31'd0, rsp_valid}, 32'd0);

    // Clock enable gating while holding one entry
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd10);
    tick();
    checkRsp("cen setup", 1'b1, 8'h77, 8'h00, 4'd10);
    clk_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15, 4'd0, 4'd11);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("cen%0d req_ready", i), {31'd0, req_ready}, 32'd0);
      tick();
      checkRsp($sformatf("cen%0d frozen", i), 1'b1, 8'h77, 8'h00, 4'd10);
    end
    clk_en = 1'b1;
    #1;
    checkOutput("cen resume req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    checkRsp("cen resume", 1'b1, 8'hFF, 8'hA0, 4'd11);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("cen drained", {31'd0, rsp_valid}, 32'd0);

    // Asynchronous reset with two entries held
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 4'd7, 4'd12);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 4'd3, 4'd13);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    checkOutput("pre-reset full", {31'd0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkRsp("async reset", 1'b0, 8'h00, 8'h00, 4'd0);
    checkOutput("async reset req_ready", {31'd0, req_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("post-reset req_ready", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
